clint_trap_ctrl: RTL and testbench

- Core-local trap controller that sits beside the CSR file.
- Consumes the CSR file's clint-side outputs: mtvec, mepc, mstatus, the global interrupt enable, the timer interrupt enable and the timer interrupt pending bit.
- Drives the CSR file's single clint write port, sequencing the mepc/mcause/mstatus updates for ecall, machine-timer interrupt and mret.
- Stalls the pipeline during the sequence and issues a one-cycle PC redirect to the handler or return address.

---
 rtl/clint_trap_ctrl_pkg.sv | 15 +
 rtl/clint_trap_ctrl.sv | 135 +++++++++++++
 tb/tb_clint_trap_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/clint_trap_ctrl_pkg.sv
// Shared CSR addresses and mstatus field positions used by the core-local trap controller.
package clint_trap_ctrl_pkg;

  localparam int unsigned CSR_ADDR_W = 12;

  localparam logic [CSR_ADDR_W-1:0] ADDR_MSTATUS = 12'h300;
  localparam logic [CSR_ADDR_W-1:0] ADDR_MEPC    = 12'h341;
  localparam logic [CSR_ADDR_W-1:0] ADDR_MCAUSE  = 12'h342;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

endpackage

// File: rtl/clint_trap_ctrl.sv
// Core-local trap controller: sequences mepc/mcause/mstatus writes for ecall, timer irq and mret,
// stalls the pipeline meanwhile and pulses a fetch redirect at the end of each sequence.
module clint_trap_ctrl
  import clint_trap_ctrl_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned ECALL_CAUSE = 11,
  parameter int unsigned MTI_CAUSE   = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inst_valid_i,
  input  logic [XLEN-1:0]       inst_pc_i,
  input  logic                  inst_ecall_i,
  input  logic                  inst_mret_i,
  input  logic [XLEN-1:0]       csr_mtvec_i,
  input  logic [XLEN-1:0]       csr_mepc_i,
  input  logic [XLEN-1:0]       csr_mstatus_i,
  input  logic                  global_int_en_i,
  input  logic                  mtime_int_en_i,
  input  logic                  mtime_int_pend_i,
  output logic                  clint_csr_wen_o,
  output logic [CSR_ADDR_W-1:0] clint_csr_waddr_o,
  output logic [XLEN-1:0]       clint_csr_wdata_o,
  output logic                  clint_stall_o,
  output logic                  clint_redirect_o,
  output logic [XLEN-1:0]       clint_redirect_pc_o
);

  typedef enum logic [2:0] {
    S_IDLE           = 3'd0,
    S_W_MEPC         = 3'd1,
    S_W_MCAUSE       = 3'd2,
    S_W_MSTATUS_TRAP = 3'd3,
    S_W_MSTATUS_MRET = 3'd4
  } state_t;

  localparam logic [XLEN-1:0] IRQ_CAUSE   = {1'b1, (XLEN-1)'(MTI_CAUSE)};
  localparam logic [XLEN-1:0] ECALL_CODE  = XLEN'(ECALL_CAUSE);
  localparam logic [XLEN-1:0] MTVEC_MASK  = {{(XLEN-2){1'b1}}, 2'b00};

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, cause_q;
  logic            idle, irq, ecall, mret, take_trap;
  logic [XLEN-1:0] mstatus_new;

  // Event detection is only live in IDLE and is held off while reset is asserted.
  assign idle      = (state_q == S_IDLE) & rst_n;
  assign irq       = idle & inst_valid_i & global_int_en_i & mtime_int_en_i & mtime_int_pend_i;
  assign ecall     = idle & inst_valid_i & inst_ecall_i;
  assign mret      = idle & inst_valid_i & inst_mret_i;
  assign take_trap = irq | ecall;

  assign clint_stall_o = (state_q != S_IDLE) | irq | ecall | mret;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Trap context captured in the detection cycle, replayed during the write sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      cause_q <= '0;
    end else if (take_trap) begin
      pc_q    <= inst_pc_i;
      cause_q <= irq ? IRQ_CAUSE : ECALL_CODE;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (take_trap) begin
          state_d = S_W_MEPC;
        end else if (mret) begin
          state_d = S_W_MSTATUS_MRET;
        end
      end
      S_W_MEPC:         state_d = S_W_MCAUSE;
      S_W_MCAUSE:       state_d = S_W_MSTATUS_TRAP;
      S_W_MSTATUS_TRAP: state_d = S_IDLE;
      S_W_MSTATUS_MRET: state_d = S_IDLE;
      default:          state_d = S_IDLE;
    endcase
  end

  always_comb begin
    clint_csr_wen_o     = 1'b0;
    clint_csr_waddr_o   = '0;
    clint_csr_wdata_o   = '0;
    clint_redirect_o    = 1'b0;
    clint_redirect_pc_o = '0;
    mstatus_new         = csr_mstatus_i;
    case (state_q)
      S_W_MEPC: begin
        clint_csr_wen_o   = 1'b1;
        clint_csr_waddr_o = ADDR_MEPC;
        clint_csr_wdata_o = pc_q;
      end
      S_W_MCAUSE: begin
        clint_csr_wen_o   = 1'b1;
        clint_csr_waddr_o = ADDR_MCAUSE;
        clint_csr_wdata_o = cause_q;
      end
      S_W_MSTATUS_TRAP: begin
        mstatus_new[MSTATUS_MPIE]                  = csr_mstatus_i[MSTATUS_MIE];
        mstatus_new[MSTATUS_MIE]                   = 1'b0;
        mstatus_new[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        clint_csr_wen_o     = 1'b1;
        clint_csr_waddr_o   = ADDR_MSTATUS;
        clint_csr_wdata_o   = mstatus_new;
        clint_redirect_o    = 1'b1;
        clint_redirect_pc_o = csr_mtvec_i & MTVEC_MASK;
      end
      S_W_MSTATUS_MRET: begin
        mstatus_new[MSTATUS_MIE]                   = csr_mstatus_i[MSTATUS_MPIE];
        mstatus_new[MSTATUS_MPIE]                  = 1'b1;
        mstatus_new[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        clint_csr_wen_o     = 1'b1;
        clint_csr_waddr_o   = ADDR_MSTATUS;
        clint_csr_wdata_o   = mstatus_new;
        clint_redirect_o    = 1'b1;
        clint_redirect_pc_o = csr_mepc_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_clint_trap_ctrl.sv
// Self-checking bench for clint_trap_ctrl: a per-cycle schedule model plus directed literal checks.
module tb_clint_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_valid, inst_ecall, inst_mret;
  logic [63:0] inst_pc, mtvec, mepc, mstatus;
  logic        gie, mtie, mtip;
  logic        wen, stall, redir;
  logic [11:0] waddr;
  logic [63:0] wdata, rpc;

  clint_trap_ctrl #(.XLEN(64), .ECALL_CAUSE(11), .MTI_CAUSE(7)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .inst_valid_i       (inst_valid),
    .inst_pc_i          (inst_pc),
    .inst_ecall_i       (inst_ecall),
    .inst_mret_i        (inst_mret),
    .csr_mtvec_i        (mtvec),
    .csr_mepc_i         (mepc),
    .csr_mstatus_i      (mstatus),
    .global_int_en_i    (gie),
    .mtime_int_en_i     (mtie),
    .mtime_int_pend_i   (mtip),
    .clint_csr_wen_o    (wen),
    .clint_csr_waddr_o  (waddr),
    .clint_csr_wdata_o  (wdata),
    .clint_stall_o      (stall),
    .clint_redirect_o   (redir),
    .clint_redirect_pc_o(rpc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: a queue of pending sequence cycles ----------------
  localparam int K_MEPC = 0, K_MCAUSE = 1, K_TRAP = 2, K_MRET = 3;
  typedef struct {
    int          kind;
    logic [63:0] val;
  } step_t;
  step_t q[$];

  function automatic logic [63:0] ms_after_trap(input logic [63:0] ms);
    return (ms & ~64'h1888) | 64'h1800 | (((ms >> 3) & 64'd1) << 7);
  endfunction

  function automatic logic [63:0] ms_after_mret(input logic [63:0] ms);
    return (ms & ~64'h1888) | 64'h1880 | (((ms >> 7) & 64'd1) << 3);
  endfunction

  logic        m_stall, m_wen, m_redir, m_irq, m_ecall, m_mret;
  logic [11:0] m_addr;
  logic [63:0] m_data, m_rpc;
  step_t       m_s;

  always @(negedge clk) begin
    m_stall = 1'b0; m_wen = 1'b0; m_redir = 1'b0;
    m_addr = 12'h0; m_data = 64'h0; m_rpc = 64'h0;
    if (!rst_n) begin
      q.delete();
    end else if (q.size() > 0) begin
      m_s = q.pop_front();
      m_stall = 1'b1;
      m_wen = 1'b1;
      case (m_s.kind)
        K_MEPC:   begin m_addr = 12'h341; m_data = m_s.val; end
        K_MCAUSE: begin m_addr = 12'h342; m_data = m_s.val; end
        K_TRAP: begin
          m_addr = 12'h300; m_data = ms_after_trap(mstatus);
          m_redir = 1'b1; m_rpc = {mtvec[63:2], 2'b00};
        end
        default: begin
          m_addr = 12'h300; m_data = ms_after_mret(mstatus);
          m_redir = 1'b1; m_rpc = mepc;
        end
      endcase
    end else begin
      m_irq   = inst_valid && gie && mtie && mtip;
      m_ecall = inst_valid && inst_ecall;
      m_mret  = inst_valid && inst_mret;
      if (m_irq || m_ecall) begin
        m_stall = 1'b1;
        q.push_back('{K_MEPC, inst_pc});
        q.push_back('{K_MCAUSE, m_irq ? 64'h8000_0000_0000_0007 : 64'd11});
        q.push_back('{K_TRAP, 64'h0});
      end else if (m_mret) begin
        m_stall = 1'b1;
        q.push_back('{K_MRET, 64'h0});
      end
    end
    chk("model_stall", 64'(stall), 64'(m_stall));
    chk("model_wen", 64'(wen), 64'(m_wen));
    chk("model_waddr", 64'(waddr), 64'(m_addr));
    chk("model_wdata", wdata, m_data);
    chk("model_redirect", 64'(redir), 64'(m_redir));
    chk("model_redirect_pc", rpc, m_rpc);
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inst();
    inst_valid = 1'b0; inst_ecall = 1'b0; inst_mret = 1'b0;
  endtask

  task automatic expect_write(input string name, input logic [11:0] a, input logic [63:0] d);
    chk({name, "_wen"}, 64'(wen), 64'd1);
    chk({name, "_waddr"}, 64'(waddr), 64'(a));
    chk({name, "_wdata"}, wdata, d);
    chk({name, "_stall"}, 64'(stall), 64'd1);
  endtask

  task automatic expect_quiet(input string name);
    chk({name, "_stall"}, 64'(stall), 64'd0);
    chk({name, "_wen"}, 64'(wen), 64'd0);
    chk({name, "_redirect"}, 64'(redir), 64'd0);
  endtask

  initial begin
    clear_inst();
    inst_pc = 64'h0; mtvec = 64'h0; mepc = 64'h0; mstatus = 64'h0;
    gie = 1'b0; mtie = 1'b0; mtip = 1'b0;

    // Reset: outputs zero even with an ecall presented.
    inst_valid = 1'b1; inst_ecall = 1'b1;
    @(negedge clk);
    expect_quiet("reset");
    chk("reset_waddr", 64'(waddr), 64'd0);
    chk("reset_wdata", wdata, 64'd0);
    chk("reset_rpc", rpc, 64'd0);
    clear_inst();
    next_cycle(); rst_n = 1'b1;
    next_cycle();

    // ecall sequence.
    mtvec = 64'h8000_0203; mstatus = 64'h1888; mepc = 64'hdead_0000;
    inst_valid = 1'b1; inst_ecall = 1'b1; inst_pc = 64'h8000_0100;
    @(negedge clk);
    chk("ecall_T_stall", 64'(stall), 64'd1);
    chk("ecall_T_wen", 64'(wen), 64'd0);
    next_cycle(); clear_inst();
    @(negedge clk); expect_write("ecall_mepc", 12'h341, 64'h8000_0100);
    @(negedge clk); expect_write("ecall_mcause", 12'h342, 64'd11);
    @(negedge clk); expect_write("ecall_mstatus", 12'h300, 64'h1880);
    chk("ecall_redirect", 64'(redir), 64'd1);
    chk("ecall_redirect_pc", rpc, 64'h8000_0200);
    @(negedge clk); expect_quiet("ecall_after");

    // Timer interrupt wins over an ecall on the same instruction.
    next_cycle();
    gie = 1'b1; mtie = 1'b1; mtip = 1'b1;
    inst_valid = 1'b1; inst_ecall = 1'b1; inst_pc = 64'h8000_0040;
    @(negedge clk); chk("irq_T_stall", 64'(stall), 64'd1);
    next_cycle(); clear_inst();
    @(negedge clk); expect_write("irq_mepc", 12'h341, 64'h8000_0040);
    @(negedge clk); expect_write("irq_mcause", 12'h342, 64'h8000_0000_0000_0007);
    @(negedge clk); expect_write("irq_mstatus", 12'h300, 64'h1880);
    chk("irq_redirect_pc", rpc, 64'h8000_0200);
    next_cycle(); gie = 1'b0;
    @(negedge clk); expect_quiet("irq_after");

    // mret.
    next_cycle();
    mstatus = 64'h1880; mepc = 64'h8000_0104;
    inst_valid = 1'b1; inst_mret = 1'b1; inst_pc = 64'h8000_0180;
    @(negedge clk); chk("mret_T_stall", 64'(stall), 64'd1);
    next_cycle(); clear_inst();
    @(negedge clk); expect_write("mret_mstatus", 12'h300, 64'h1888);
    chk("mret_redirect", 64'(redir), 64'd1);
    chk("mret_redirect_pc", rpc, 64'h8000_0104);
    @(negedge clk); expect_quiet("mret_after");

    // MIE=0 masks a pending, enabled timer irq; raising MIE takes it that cycle.
    next_cycle();
    mstatus = 64'h0008; gie = 1'b0; mtie = 1'b1; mtip = 1'b1;
    inst_valid = 1'b1; inst_pc = 64'h8000_0300;
    @(negedge clk); expect_quiet("masked_0");
    @(negedge clk); expect_quiet("masked_1");
    next_cycle(); gie = 1'b1;
    @(negedge clk); chk("unmask_T_stall", 64'(stall), 64'd1);
    next_cycle(); clear_inst();
    @(negedge clk); expect_write("unmask_mepc", 12'h341, 64'h8000_0300);
    @(negedge clk); expect_write("unmask_mcause", 12'h342, 64'h8000_0000_0000_0007);
    @(negedge clk); expect_write("unmask_mstatus", 12'h300, 64'h1880);
    next_cycle(); gie = 1'b0;
    @(negedge clk); expect_quiet("unmask_after");

    // Asynchronous reset during the mcause write abandons the sequence.
    next_cycle();
    mstatus = 64'h1888;
    inst_valid = 1'b1; inst_ecall = 1'b1; inst_pc = 64'h8000_0500;
    next_cycle(); clear_inst();
    @(negedge clk); expect_write("rst_seq_mepc", 12'h341, 64'h8000_0500);
    @(posedge clk); #2; rst_n = 1'b0;
    #1;
    expect_quiet("rst_async");
    chk("rst_async_waddr", 64'(waddr), 64'd0);
    chk("rst_async_wdata", wdata, 64'd0);
    @(negedge clk); expect_quiet("rst_hold_0");
    @(negedge clk); expect_quiet("rst_hold_1");
    next_cycle(); rst_n = 1'b1;
    @(negedge clk); expect_quiet("rst_release");
    next_cycle();
    mstatus = 64'h1880; inst_valid = 1'b1; inst_mret = 1'b1;
    @(negedge clk); chk("rst_idle_mret_stall", 64'(stall), 64'd1);
    next_cycle(); clear_inst();
    @(negedge clk); expect_write("rst_idle_mret", 12'h300, 64'h1888);
    chk("rst_idle_mret_pc", rpc, 64'h8000_0104);

    // No valid instruction: neither ecall nor pending irq acts.
    next_cycle();
    inst_valid = 1'b0; inst_ecall = 1'b1; gie = 1'b1; mtie = 1'b1; mtip = 1'b1;
    @(negedge clk); expect_quiet("novalid_0");
    @(negedge clk); expect_quiet("novalid_1");
    @(negedge clk); expect_quiet("novalid_2");
    next_cycle(); clear_inst(); gie = 1'b0;
    next_cycle();
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
